multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle ARM-style datapath: fetch, decode, execute, memory and writeback.
- Drives the ALU decoder's alu_op input, the datapath mux selects and the write strobes.
- Handshakes with a variable-latency memory port.
- Sits between the instruction register and the datapath; condition checking is external and arrives as cond_ex.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for mem_ready before abort; 0 disables timeout.
- CNT_W, 32: width of the optional retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 undefined
- funct  in  6  instr funct field; [5]=immediate, [4:1]=ALU cmd, [0]=S (data-proc) / L (memory)
- cond_ex  in  1  condition passed, from external cond check
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- adr_src  out  1  0=PC, 1=ALU result as memory address
- alu_src_a  out  2  00 reg A, 01 PC, 10 ALU out
- alu_src_b  out  2  00 reg B, 01 imm, 10 const 4
- result_src  out  2  00 ALU out, 01 mem data, 10 ALU result
- alu_op  out  1  to ALU decoder: 1 = decode funct, 0 = fixed ctrl 0000
- flag_w_en  out  1  permits ALU decoder flag_w to update flags
- illegal  out  1  one-cycle pulse on undefined op
- mem_err  out  1  one-cycle pulse on memory timeout
- state_o  out  4  current state encoding, debug

Behaviour:
- States, 4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Reset: state <= FETCH and wait counter <= 0. While rst=1, every strobe is forced 0 (mem_req, mem_we, ir_write, pc_write, reg_write, illegal, mem_err). Selects read 0; state_o=0.
- Outputs are combinational from state and the inputs listed per state. No other output latency.
- FETCH:
  - mem_req=1, adr_src=0.
  - Holds until mem_ready=1. On that cycle ir_write=1, pc_write=1, alu_src_a=01, alu_src_b=10, result_src=10. Then go to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=10 (PC+8 read).
  - Next state: op=01 -> MEMADR; op=00 -> EXECI if funct[5] else EXECR; op=10 -> BRANCH; op=11 -> illegal=1, FETCH.
- MEMADR: alu_src_a=00, alu_src_b=01. Next: funct[0] ? MEMRD : MEMWR.
- MEMRD: mem_req=1, adr_src=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex. Next: FETCH.
- MEMWR:
  - mem_req=1, mem_we=cond_ex, adr_src=1.
  - If cond_ex=0, go straight to FETCH with mem_req=0. Otherwise hold until mem_ready, then FETCH.
- EXECR / EXECI:
  - alu_op=1, alu_src_a=00, alu_src_b=00 (EXECR) or 01 (EXECI).
  - flag_w_en=cond_ex. Next: ALUWB.
- ALUWB:
  - result_src=00, alu_op=1.
  - reg_write=cond_ex AND NOT(funct[4:1]==10 or funct[4:1]==11); compares never write back.
  - Next: FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=01, result_src=10, pc_write=cond_ex. Next: FETCH.
- alu_op=0 in every state other than EXECR, EXECI and ALUWB.
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR, and increments each stalled cycle.
  - If MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT with mem_ready=0: mem_err=1 for one cycle, mem_req drops, state -> FETCH, no strobes issue.
  - A FETCH timeout re-fetches from the unchanged PC.
- mem_ready seen in the same cycle the timeout is reached: mem_ready wins, and the access completes normally.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- rst asserted mid-access: state returns to FETCH next edge. mem_req is 0 during the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTR_CNT_EN.
- Defined:
  - Adds output instr_count[CNT_W-1:0], reset to 0.
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH, whether cond_ex passed or not.
  - Not incremented on illegal or mem_err aborts. Wraps modulo 2^CNT_W.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package multicycle_pkg holds:
  - state enum ctrl_state_t;
  - op class constants OP_DP/OP_MEM/OP_BR;
  - mux select constants SRCA_*/SRCB_*/RES_*;
  - CMD_CMP=4'd10 and CMD_CMN=4'd11.
- One sub-module, mem_wait_timer: the wait counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1 -> state_o 0 then 1. ir_write and pc_write pulse exactly once at the first post-reset FETCH.
- Data-proc ADD register, op=00, funct=6'b001001, cond_ex=1 -> FETCH, DECODE, EXECR, ALUWB, FETCH. alu_op=1 in EXECR/ALUWB. flag_w_en=1, reg_write=1 in ALUWB.
- CMP, funct=6'b010101 -> flag_w_en=1 in EXECR; reg_write=0 in ALUWB.
- LDR, op=01, funct[0]=1, mem_ready delayed 3 cycles in MEMRD -> MEMRD held 3 cycles with mem_req=1, adr_src=1. MEMWB reg_write=1, result_src=01.
- STR with cond_ex=0 -> MEMWR lasts 1 cycle with mem_req=0 and mem_we=0, then FETCH.
- FETCH with mem_ready stuck 0, MEM_TIMEOUT=15 -> mem_err pulses on the 15th stall cycle, state FETCH restarts, pc_write never asserted. op=11 in DECODE -> illegal pulse, then FETCH.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Purpose : shared definitions for the multicycle ARM-style controller:
//           FSM state encoding, instruction-class codes, datapath mux
//           select codes and the ALU commands that never write back.
// Contents: ctrl_state_t, OP_*, SRCA_*, SRCB_*, RES_*, CMD_CMP/CMD_CMN,
//           is_compare().
package multicycle_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } ctrl_state_t;

    // Instruction classes (op field); 2'b11 is undefined.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALU operand A select.
    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;
    localparam logic [1:0] SRCA_ALU = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Flag-only ALU commands.
    localparam logic [3:0] CMD_CMP = 4'd10;
    localparam logic [3:0] CMD_CMN = 4'd11;

    function automatic logic is_compare(input logic [3:0] cmd);
        return (cmd == CMD_CMP) || (cmd == CMD_CMN);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose : counts consecutive stalled cycles of one memory access and flags
//           the cycle on which the MEM_TIMEOUT-th stall occurs.
// Ports   : clk, rst    - clock, synchronous active-high reset
//           stall       - access in progress and mem_ready low this cycle
//           expired     - this stall cycle is the last one allowed
// Params  : MEM_TIMEOUT - stall cycles before abort; 0 disables the timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

            // Stalls already completed in this access; the current cycle is
            // stall number count+1. Any non-stalled cycle (completion,
            // abort, or a state that is not waiting) clears it, so every
            // access starts counting from zero.
            logic [CW-1:0] count;

            assign expired = stall && (count == CW'(MEM_TIMEOUT - 1));

            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk) begin
                if (rst)
                    count <= '0;
                else if (stall && !expired)
                    count <= count + CW'(1);
                else
                    count <= '0;
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : Moore-style control FSM for a multicycle ARM-like datapath
//           (fetch, decode, execute, memory, writeback) with a
//           variable-latency memory handshake and access timeout.
// Ports   : clk, rst (sync, active high); op, funct, cond_ex, mem_ready in;
//           mem_req, mem_we, ir_write, pc_write, reg_write strobes;
//           adr_src, alu_src_a, alu_src_b, result_src mux selects;
//           alu_op, flag_w_en to the ALU decoder; illegal, mem_err pulses;
//           state_o debug view of the state register.
// Option  : define MULTICYCLE_CTRL_INSTR_CNT_EN to add instr_count, a
//           CNT_W-bit count of instructions that ran to completion.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic             cond_ex,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             adr_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic             alu_op,
    output logic             flag_w_en,
    output logic             illegal,
    output logic             mem_err,
    output logic [3:0]       state_o
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);

    ctrl_state_t state, next_state;
    logic        wait_stall;
    logic        expired;

    // A conditional store that fails never touches memory, so it never
    // stalls either.
    assign wait_stall = !rst && !mem_ready &&
                        ((state == FETCH) || (state == MEMRD) ||
                         ((state == MEMWR) && cond_ex));

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .stall  (wait_stall),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= next_state;
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        flag_w_en  = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // PC+4 goes through the ALU while the IR loads.
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    next_state = DECODE;
                end else if (expired) begin
                    // PC untouched, so the retry re-fetches the same word.
                    mem_req = 1'b0;
                    mem_err = 1'b1;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                case (op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = funct[5] ? EXECI : EXECR;
                    OP_BR:   next_state = BRANCH;
                    default: begin
                        illegal    = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                next_state = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end else if (expired) begin
                    mem_req    = 1'b0;
                    mem_err    = 1'b1;
                    next_state = FETCH;
                end
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = cond_ex;
                next_state = FETCH;
            end
            MEMWR: begin
                adr_src = 1'b1;
                if (!cond_ex) begin
                    next_state = FETCH;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_ready) begin
                        next_state = FETCH;
                    end else if (expired) begin
                        mem_req    = 1'b0;
                        mem_we     = 1'b0;
                        mem_err    = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            EXECR, EXECI: begin
                alu_op     = 1'b1;
                alu_src_a  = SRCA_REG;
                alu_src_b  = (state == EXECI) ? SRCB_IMM : SRCB_REG;
                flag_w_en  = cond_ex;
                next_state = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                alu_op     = 1'b1;
                reg_write  = cond_ex && !is_compare(funct[4:1]);
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = SRCA_ALU;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = cond_ex;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        // Outputs are quiet during reset even though the state register
        // only clears on the edge.
        state_o = state;
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            adr_src    = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            alu_op     = 1'b0;
            flag_w_en  = 1'b0;
            illegal    = 1'b0;
            mem_err    = 1'b0;
            state_o    = 4'd0;
        end
    end

`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
    // Counts instructions reaching their final state, whether or not the
    // condition passed; illegal and timeout aborts are excluded.
    logic retire;

    assign retire = (next_state == FETCH) &&
                    ((state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                     ((state == MEMWR) && !mem_err));

    always_ff @(posedge clk) begin
        if (rst)
            instr_count <= '0;
        else if (retire)
            instr_count <= instr_count + CNT_W'(1);
    end
`endif

endmodule
